dct_stream_framer: RTL
======================

# dct_stream_framer

- Ping-pong input framer in front of `DCT_Engine`.
- Accepts a serial stream of IEEE-754 samples (`M+E+1` bits) over a valid/ready handshake and groups them into frames of `DCT_POINT` samples.
- Emits each completed frame to the engine in natural or bit-reversed order, so one frame can fill while the previous one drains.
- Replaces the free-running `en`/`inp` streaming with flow control, frame marking and a framing check.

## Interface
- `DCT_POINT`, 16, samples per frame; power of two, ≥2.
- `M`, 23, mantissa width.
- `E`, 8, exponent width; sample width W = M+E+1.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `en` input 1: global enable; when low, both handshakes stall and all state holds.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: framer accepts `in_data` this cycle.
- `in_data` input W: sample, {sign, exponent, mantissa}.
- `in_last` input 1: producer's end-of-frame marker; checked only, not used for framing.
- `bitrev_mode` input 1: 0 = natural read order, 1 = bit-reversed read order.
- `out_valid` output 1: `out_data` is valid.
- `out_ready` input 1: engine accepts `out_data`.
- `out_data` output W: sample.
- `out_index` output log2(DCT_POINT): original position of the sample within its frame.
- `out_last` output 1: final sample of the frame.
- `frame_err` output 1: one-cycle pulse on an `in_last` mismatch.

## Operation
**Storage**
- Two banks of DCT_POINT×W registers.
- Per bank: a full flag.
- Write pointer: `wr_bank` plus `wr_idx`.
- Read pointer: `rd_bank` plus `rd_cnt`.

**Write side**
- `in_ready = en & ~full[wr_bank]`.
- On each accept, store the sample at `wr_idx`, then increment `wr_idx`.
- Accept at `wr_idx == DCT_POINT-1`: set `full[wr_bank]`, toggle `wr_bank`, clear `wr_idx`.
- Sample count is authoritative for framing.

**Read side**
- `out_valid = en & full[rd_bank]`.
- Read address = `rd_cnt` when `bitrev_mode` = 0; bit-reverse(`rd_cnt`) when 1.
- `bitrev_mode` is latched when `rd_cnt == 0` and `full[rd_bank]`; changes mid-frame are ignored.
- `out_index` = read address.
- `out_last = out_valid & (rd_cnt == DCT_POINT-1)`.
- On handshake: increment `rd_cnt`.
- Handshake on the last sample: clear `full[rd_bank]`, toggle `rd_bank`, clear `rd_cnt`.

**Framing check (`frame_err`)**
- Pulses when `in_last`=1 is accepted at `wr_idx ≠ DCT_POINT-1`.
- Pulses when `in_last`=0 is accepted at `wr_idx == DCT_POINT-1`.

**Output forcing**
- `out_data`, `out_index` and `out_last` are forced to 0 while `out_valid` = 0.

**Reset values**
- Outputs: `in_ready`=0 during reset (goes to `en` afterwards), `out_valid`=0, `out_data`=0, `out_index`=0, `out_last`=0, `frame_err`=0.
- All pointers, counters and full flags are cleared to 0.
- Bank contents are not reset.

## Timing
- **Latency:** `out_valid` rises the cycle after the accepting edge of a frame's last sample.
- **Throughput:** one sample per cycle on each side, sustained indefinitely when `out_ready`=1.
- **Both banks full:** `in_ready`=0 until the last-sample read handshake. `in_ready` rises the cycle after that edge, because the full flag is registered; there is no same-cycle write-through.
- **Both banks empty:** `out_valid`=0.
- **Simultaneous last write and last read on different banks:** both take effect on the same edge.
- **`en` low:** no accepts and no handshakes. Pointers, flags and latched mode hold. Output fields read 0.
- **`reset` mid-frame:**
  - The partial write frame and any unread frames are discarded.
  - The next accepted sample is index 0 of bank 0.
- **Index wrap:** at DCT_POINT-1 the index returns to 0 together with the bank toggle.

## Configuration
- `DCT_FRAMER_DENORM_FLUSH_EN` defined: on write, any sample with exponent field 0 and mantissa ≠ 0 is stored as signed zero (sign kept; exponent and mantissa set to 0).
- Not defined: samples are stored bit-exact.
- NaN and Inf pass unchanged in both builds.

## Structure
- Package `dct_pkg` holds:
  - `DCT_POINT`, `M`, `E` defaults;
  - the sample typedef (W-bit {sign, exp, man});
  - `function bitrev(idx, n)`;
  - `function is_denorm(sample)`.
- One sub-module, `dct_pingpong_bank`: two register banks with write port, combinational read port and full flags.
- Pointer and handshake logic stays in `dct_stream_framer`.

## Test plan
All scenarios use DCT_POINT=16, M=23, E=8. Frame A = 41200000, 41A00000, 00000000, C0A00000, 41F00000, 41400000, 42040000, C0800000, 41900000, 41400000, C1100000, 40000000, C0E00000, 41980000, 40000000, 41A80000.

- **Natural order:** frame A back-to-back, `out_ready`=1, `bitrev_mode`=0 → `out_valid` rises 1 cycle after the 16th accept; `out_data` sequence = frame A; `out_index` 0..15; `out_last` only on 41A80000.
- **Bit-reversed order:** frame A with `bitrev_mode`=1 → `out_index` 0, 8, 4, 12, 2, 10, …; `out_data` 41200000, 41900000, 41F00000, C0E00000, 00000000, C1100000, …. Toggling `bitrev_mode` mid-frame does not change the order.
- **Backpressure:** `out_ready`=0, stream frame A continuously → `in_ready` falls after 32 accepts; raise `out_ready` → `in_ready` rises the cycle after the first `out_last` handshake; no sample is lost or duplicated across 3 frames.
- **Denormal flush:** inputs 80000001 and 00400000 → with the macro, output 80000000 and 00000000; without the macro, unchanged. 7F800000 is passed through in both builds.
- **Framing error:** `in_last`=1 on sample 10 → `frame_err` 1-cycle pulse; frame still closes at 16 samples; `in_last` missing on sample 15 → a second pulse.
- **Reset and enable:**
  - Assert `reset` after 7 accepts → all outputs 0; the next 16 samples emerge as a clean frame with indices 0..15.
  - Drop `en` for 5 cycles mid-read → the output resumes at the same index.

Source files
------------

// File: rtl/dct_pkg.sv
// Shared types and helpers for the DCT input framer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: default frame/format sizes, the IEEE-754 sample struct,
// bitrev() for index reversal and is_denorm() for a sample_t.
package dct_pkg;

    localparam int DCT_POINT_DFLT = 16;
    localparam int M_DFLT         = 23;
    localparam int E_DFLT         = 8;

    typedef struct packed {
        logic              sign;
        logic [E_DFLT-1:0] exp;
        logic [M_DFLT-1:0] man;
    } sample_t;

    // Reverse the low n bits of idx; bits at and above n come back as 0.
    function automatic logic [31:0] bitrev(input logic [31:0] idx, input int n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < n) begin
                r = r | (((idx >> i) & 32'd1) << (n - 1 - i));
            end
        end
        return r;
    endfunction

    // Subnormal: zero exponent field with a non-zero mantissa.
    function automatic logic is_denorm(input sample_t s);
        return (s.exp == '0) && (s.man != '0);
    endfunction

endpackage

// File: rtl/dct_stream_framer_if.sv
// Handshake bundle between sample producer, framer and DCT engine.
// Latency: n/a (wiring only).
// Backpressure: in_ready/out_ready carry the valid/ready stall in each direction.
// slave  = framer view (consumes in_*, produces out_*, frame_err).
// master = environment view (produces in_*, bitrev_mode, out_ready).
interface dct_stream_framer_if #(
    parameter int W  = 32,
    parameter int IW = 4
) ();
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_last;
    logic          bitrev_mode;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [IW-1:0] out_index;
    logic          out_last;
    logic          frame_err;

    modport slave (
        input  in_valid, in_data, in_last, bitrev_mode, out_ready,
        output in_ready, out_valid, out_data, out_index, out_last, frame_err
    );

    modport master (
        output in_valid, in_data, in_last, bitrev_mode, out_ready,
        input  in_ready, out_valid, out_data, out_index, out_last, frame_err
    );
endinterface

// File: rtl/dct_pingpong_bank.sv
// Two sample banks with a write port, combinational read port and per-bank full flags.
// Latency: write visible on the next cycle; read is combinational.
// Backpressure: none internally; the caller only writes a non-full bank and reads a full one.
// Ports: clk/reset, wr_en/wr_bank/wr_addr/wr_data, wr_close (mark bank full),
// rd_bank/rd_addr -> rd_data, rd_close (mark bank empty), full[1:0].
module dct_pingpong_bank #(
    parameter int N = 16,
    parameter int W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic                 wr_bank,
    input  logic [$clog2(N)-1:0] wr_addr,
    input  logic [W-1:0]         wr_data,
    input  logic                 wr_close,
    input  logic                 rd_bank,
    input  logic [$clog2(N)-1:0] rd_addr,
    input  logic                 rd_close,
    output logic [W-1:0]         rd_data,
    output logic [1:0]           full
);
    // Storage is deliberately not reset: a bank is only read once it has
    // been completely written since the last reset.
    logic [W-1:0] mem [2][N];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank][wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_bank][rd_addr];

    // Closing a write and closing a read always hit different banks (one
    // is non-full, the other full), so both updates can land together.
    always_ff @(posedge clk) begin
        if (reset) begin
            full <= '0;
        end else begin
            if (wr_close) full[wr_bank] <= 1'b1;
            if (rd_close) full[rd_bank] <= 1'b0;
        end
    end
endmodule

// File: rtl/dct_stream_framer.sv
// Ping-pong framer: groups serial samples into DCT_POINT frames, emits them natural or bit-reversed.
// Latency: out_valid rises the cycle after a frame's last sample is accepted.
// Backpressure: in_ready drops while both banks are full; out side stalls on out_ready; en=0 freezes both.
// Ports: clk, reset (sync, active-high), en, s (slave modport: in_valid/in_ready/in_data/in_last,
// bitrev_mode, out_valid/out_ready/out_data/out_index/out_last, frame_err).
// Build option: DCT_FRAMER_DENORM_FLUSH_EN flushes subnormal inputs to signed zero on write.
module dct_stream_framer
    import dct_pkg::*;
#(
    parameter int DCT_POINT = DCT_POINT_DFLT,
    parameter int M         = M_DFLT,
    parameter int E         = E_DFLT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    dct_stream_framer_if.slave  s
);
    localparam int            W        = M + E + 1;
    localparam int            IW       = $clog2(DCT_POINT);
    localparam logic [IW-1:0] LAST_IDX = IW'(DCT_POINT - 1);

    logic          wr_bank, rd_bank;
    logic [IW-1:0] wr_idx, rd_cnt, rd_addr;
    logic          mode_q;
    logic          frame_err_q;
    logic [1:0]    full;
    logic [W-1:0]  wr_data, rd_data;
    logic          valid_int, accept, hs, wr_close, rd_close;

    assign s.in_ready = ~reset & en & ~full[wr_bank];
    assign valid_int  = ~reset & en & full[rd_bank];
    assign accept     = s.in_valid & s.in_ready;
    assign hs         = valid_int & s.out_ready;
    // The sample count closes a frame; in_last only feeds the framing check.
    assign wr_close   = accept & (wr_idx == LAST_IDX);
    assign rd_close   = hs & (rd_cnt == LAST_IDX);

    // At rd_cnt == 0 the address is 0 in either mode, so the not-yet-latched
    // mode_q cannot affect the first sample.
    assign rd_addr = mode_q ? IW'(bitrev(32'(rd_cnt), IW)) : rd_cnt;

    always_comb begin
        wr_data = s.in_data;
`ifdef DCT_FRAMER_DENORM_FLUSH_EN
        // NaN/Inf have an all-ones exponent and are left untouched.
        if ((s.in_data[M+E-1:M] == '0) && (s.in_data[M-1:0] != '0)) begin
            wr_data = {s.in_data[W-1], {(W-1){1'b0}}};
        end
`endif
    end

    dct_pingpong_bank #(.N(DCT_POINT), .W(W)) u_bank (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (accept),
        .wr_bank  (wr_bank),
        .wr_addr  (wr_idx),
        .wr_data  (wr_data),
        .wr_close (wr_close),
        .rd_bank  (rd_bank),
        .rd_addr  (rd_addr),
        .rd_close (rd_close),
        .rd_data  (rd_data),
        .full     (full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_bank     <= 1'b0;
            wr_idx      <= '0;
            rd_bank     <= 1'b0;
            rd_cnt      <= '0;
            mode_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= accept & (s.in_last != (wr_idx == LAST_IDX));
            // Mode is sampled while a frame waits at its first sample, so a
            // change mid-frame only applies to the next frame.
            if (valid_int && (rd_cnt == '0)) begin
                mode_q <= s.bitrev_mode;
            end
            if (accept) begin
                wr_idx <= wr_close ? '0 : wr_idx + 1'b1;
                if (wr_close) wr_bank <= ~wr_bank;
            end
            if (hs) begin
                rd_cnt <= rd_close ? '0 : rd_cnt + 1'b1;
                if (rd_close) rd_bank <= ~rd_bank;
            end
        end
    end

    assign s.out_valid = valid_int;
    assign s.out_data  = valid_int ? rd_data : '0;
    assign s.out_index = valid_int ? rd_addr : '0;
    assign s.out_last  = valid_int & (rd_cnt == LAST_IDX);
    assign s.frame_err = frame_err_q;
endmodule
